// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU take WIDTH+2 edges,
// MTHI/MTLO write in one edge. Sign handling is done on magnitudes around the loop.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_ah;
  logic [WIDTH-1:0] r_al;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;

  logic             w_is_md;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rmd;

  always_comb begin
    w_is_md = ~op_i[2];
    w_neg_a = ~op_i[0] & rs_i[WIDTH-1];
    w_neg_b = ~op_i[0] & rt_i[WIDTH-1];
    w_abs_a = w_neg_a ? -rs_i : rs_i;
    w_abs_b = w_neg_b ? -rt_i : rt_i;
  end

  // Both loops share {r_ah, r_al}: multiply shifts the product right through it,
  // divide shifts the dividend left out of r_al into the partial remainder r_ah.
  always_comb begin
    w_madd = {1'b0, r_ah} + (r_al[0] ? {1'b0, r_b} : '0);
    w_rem  = {r_ah, r_al[WIDTH-1]};
    w_diff = w_rem - {1'b0, r_b};
  end

  // A zero divisor leaves the quotient all ones and the remainder equal to |rs|;
  // restoring the dividend sign on that remainder yields rs itself.
  always_comb begin
    w_prod     = {r_ah, r_al};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_quo      = r_dz ? '1 : (r_neg_q ? -r_al : r_al);
    w_rmd      = r_neg_r ? -r_ah : r_ah;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ah    <= '0;
      r_al    <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !cancel_i) begin
            if (w_is_md) begin
              r_ah    <= '0;
              r_al    <= w_abs_a;
              r_b     <= w_abs_b;
              r_div   <= op_i[1];
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
              r_dz    <= op_i[1] & (rt_i == '0);
              r_cnt   <= CW'(WIDTH - 1);
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end else if (op_i == 3'b100) begin
              r_hi <= rs_i;
            end else if (op_i == 3'b101) begin
              r_lo <= rs_i;
            end
          end
        end
        S_CALC: begin
          if (cancel_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_div) begin
              r_ah <= w_diff[WIDTH] ? w_rem[WIDTH-1:0] : w_diff[WIDTH-1:0];
              r_al <= {r_al[WIDTH-2:0], ~w_diff[WIDTH]};
            end else begin
              {r_ah, r_al} <= {w_madd, r_al[WIDTH-1:1]};
            end
            if (r_cnt == '0) begin
              r_state <= S_SIGN;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_SIGN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!cancel_i) begin
            if (r_div) begin
              r_hi <= w_rmd;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
            r_done <= 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes reference results, a negedge
// monitor pops and checks them (values and latency) whenever done_o pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .op_i    (op),
    .rs_i    (rs),
    .rt_i    (rt),
    .cancel_i(cancel),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cur_hi   = '0;
  logic [31:0] cur_lo   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: full-width integer arithmetic, HI in the upper half of the result.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub, uq, ur;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      3'd0: return sa * sbv;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sbq.pop_front();
        chk("result_hi", hi, mon_e.hi);
        chk("result_lo", lo, mon_e.lo);
        chk("latency", 32'(cyc - mon_e.acc), 32'd33);
        cur_hi = mon_e.hi;
        cur_lo = mon_e.lo;
      end
    end
  end

  task automatic wait_ready(input bit need_empty);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((busy || (need_empty && sbq.size() != 0)) && n < 300);
    if (busy || (need_empty && sbq.size() != 0)) begin
      checks++;
      failures++;
      $display("FAIL wait_ready_timeout actual=busy%0d_q%0d required=idle", busy, sbq.size());
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    exp_t        e;
    logic [63:0] m;
    wait_ready(1'b0);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (track) begin
      m     = ref_model(o, a, b);
      e.hi  = m[63:32];
      e.lo  = m[31:0];
      e.acc = cyc;
      sbq.push_back(e);
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] v);
    wait_ready(1'b1);
    start = 1'b1;
    op    = to_hi ? 3'b100 : 3'b101;
    rs    = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (to_hi) cur_hi = v;
    else       cur_lo = v;
    chk(to_hi ? "mthi_hi" : "mtlo_lo", to_hi ? hi : lo, v);
    chk("mt_busy", {31'd0, busy}, 32'd0);
    chk("mt_done", {31'd0, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 3'b000;
    rs     = '0;
    rt     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
    issue(3'd0, 32'h0000_0000, 32'h1234_5678, 1'b1);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    issue(3'd3, 32'h0000_0007, 32'h0000_0000, 1'b1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd3, 32'h8000_0000, 32'h0000_0003, 1'b1);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1);
    issue(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1);

    mt(1'b1, 32'h0000_1234);
    mt(1'b0, 32'hCAFE_F00D);

    // start requests while busy must be dropped, not queued
    issue(3'd1, 32'h0001_0003, 32'h0002_0005, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    start = 1'b1;
    op    = 3'd3;
    rs    = 32'h0000_0064;
    rt    = 32'h0000_0007;
    repeat (3) @(negedge clk);
    op = 3'b100;
    repeat (2) @(negedge clk);
    #2;
    start = 1'b0;
    chk("ignored_start_busy", {31'd0, busy}, 32'd1);
    chk("ignored_start_hi", hi, cur_hi);

    // cancel mid-divide
    wait_ready(1'b1);
    issue(3'd2, 32'h1234_5678, 32'h0000_0013, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, cur_hi);
    chk("cancel_lo", lo, cur_lo);
    repeat (40) @(negedge clk);
    chk("cancel_hi_later", hi, cur_hi);
    chk("cancel_lo_later", lo, cur_lo);

    // cancel together with start in IDLE
    wait_ready(1'b1);
    start  = 1'b1;
    cancel = 1'b1;
    op     = 3'b100;
    rs     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    op = 3'd2;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    chk("cancel_start_hi", hi, cur_hi);
    chk("cancel_start_busy", {31'd0, busy}, 32'd0);

    // 11x opcodes do nothing
    start = 1'b1;
    op    = 3'b110;
    rs    = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    op = 3'b111;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("noop_busy", {31'd0, busy}, 32'd0);
    chk("noop_hi", hi, cur_hi);
    chk("noop_lo", lo, cur_lo);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) mt($urandom_range(0, 1) == 1, $urandom);
      issue(3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b1);
    end

    // reset mid-divide clears everything
    wait_ready(1'b1);
    issue(3'd3, 32'hFFFF_0000, 32'h0000_0011, 1'b0);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    rst    = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    repeat (40) @(negedge clk);
    chk("rst_mid_hi_later", hi, 32'd0);

    issue(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    wait_ready(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
